lfsr_gen_param: RTL and testbench



---
 rtl/lfsr_gen_param.sv | 86 ++++++++
 tb/tb_lfsr_gen_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen_param.sv
// Parametrised Fibonacci LFSR with seed load, enable gating, valid strobe, lockup flag and wrap pulse.
// Optional: define LFSR_LOCKUP_RECOVER_EN to steer zero seeds to DEFAULT_SEED.
module lfsr_gen_param #(
  parameter int unsigned      WIDTH        = 31,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(32'h48000020),
  parameter int unsigned      STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             qzt_clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             lockup,
  output logic             wrap
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] adv_c;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;
  logic             wrap_q, wrap_d;

  // STEPS single-bit Fibonacci shifts unrolled into one combinational advance
  always_comb begin
    adv_c = state_q;
    for (int unsigned k = 0; k < STEPS; k++) begin
      adv_c = {adv_c[WIDTH-2:0], ^(adv_c & TAPS)};
    end
  end

  // Load has priority over advance; idle holds state and drops the strobes
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (seed_load) begin
      valid_d = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
      state_d = (seed == '0) ? DEFAULT_SEED : seed;
`else
      state_d = seed;
`endif
      ref_d   = state_d;
    end else if (enable) begin
      valid_d = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
      state_d = (adv_c == '0) ? DEFAULT_SEED : adv_c;
`else
      state_d = adv_c;
`endif
      wrap_d  = (state_d == ref_q);
    end
`ifdef LFSR_LOCKUP_RECOVER_EN
    lock_d = seed_load && (seed == '0);
`else
    lock_d = (state_d == '0);
`endif
  end

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEFAULT_SEED;
      ref_q   <= DEFAULT_SEED;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out       = state_q;
  assign out_valid = valid_q;
  assign lockup    = lock_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_lfsr_gen_param.sv
// Scoreboard bench for lfsr_gen_param: three parameter sets driven in lockstep against a behavioural model.
module tb_lfsr_gen_param;

  logic        qzt_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        seed_load = 1'b0;
  logic        enable    = 1'b0;
  logic [63:0] seed      = '0;

  logic [30:0] out_a, out_b;
  logic [3:0]  out_c;
  logic        v_a, v_b, v_c, lk_a, lk_b, lk_c, wr_a, wr_b, wr_c;

  int checks = 0;
  int errors = 0;

  always #5 qzt_clk = ~qzt_clk;

  lfsr_gen_param u_a (
    .qzt_clk(qzt_clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed[30:0]),
    .enable(enable), .out(out_a), .out_valid(v_a), .lockup(lk_a), .wrap(wr_a));

  lfsr_gen_param #(.WIDTH(31), .STEPS(2)) u_b (
    .qzt_clk(qzt_clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed[30:0]),
    .enable(enable), .out(out_b), .out_valid(v_b), .lockup(lk_b), .wrap(wr_b));

  lfsr_gen_param #(.WIDTH(4), .TAPS(4'b1100), .STEPS(1), .DEFAULT_SEED(4'h1)) u_c (
    .qzt_clk(qzt_clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed[3:0]),
    .enable(enable), .out(out_c), .out_valid(v_c), .lockup(lk_c), .wrap(wr_c));

  typedef struct packed {
    logic [2:0]       v;
    logic [2:0]       lk;
    logic [2:0]       wr;
    logic [2:0][63:0] o;
  } exp_t;

  exp_t exp_q[$];

  int          mw [3] = '{31, 31, 4};
  int          ms [3] = '{1, 2, 1};
  logic [63:0] mt [3] = '{64'h48000020, 64'h48000020, 64'hC};
  logic [63:0] st [3] = '{64'd1, 64'd1, 64'd1};
  logic [63:0] rf [3] = '{64'd1, 64'd1, 64'd1};

  logic [63:0] act_o  [3];
  logic [2:0]  act_v, act_lk, act_wr;

  always_comb begin
    act_o[0] = 64'(out_a);
    act_o[1] = 64'(out_b);
    act_o[2] = 64'(out_c);
    act_v    = {v_c, v_b, v_a};
    act_lk   = {lk_c, lk_b, lk_a};
    act_wr   = {wr_c, wr_b, wr_a};
  end

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Spec rule: each shift appends XOR of tapped bits at the bottom
  function automatic logic [63:0] advance(input logic [63:0] s, input int w,
                                          input logic [63:0] taps, input int steps);
    logic [63:0] r;
    r = s;
    for (int k = 0; k < steps; k++) begin
      r = ((r << 1) | 64'(^(r & taps))) & mask_of(w);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and push the model's prediction for the following edge
  task automatic drive(input logic ld, input logic [63:0] sd, input logic en);
    exp_t e;
    logic [63:0] s, n;
    @(negedge qzt_clk);
    seed_load = ld;
    seed      = sd;
    enable    = en;
    for (int i = 0; i < 3; i++) begin
      s = sd & mask_of(mw[i]);
      e.v[i]  = ld | en;
      e.wr[i] = 1'b0;
      if (ld) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
        st[i]   = (s == 0) ? 64'd1 : s;
        e.lk[i] = (s == 0);
`else
        st[i]   = s;
        e.lk[i] = (s == 0);
`endif
        rf[i] = st[i];
      end else if (en) begin
        n = advance(st[i], mw[i], mt[i], ms[i]);
`ifdef LFSR_LOCKUP_RECOVER_EN
        if (n == 0) n = 64'd1;
        e.lk[i] = 1'b0;
`else
        e.lk[i] = (n == 0);
`endif
        st[i]   = n;
        e.wr[i] = (n == rf[i]);
      end else begin
`ifdef LFSR_LOCKUP_RECOVER_EN
        e.lk[i] = 1'b0;
`else
        e.lk[i] = (st[i] == 0);
`endif
      end
      e.o[i] = st[i];
    end
    exp_q.push_back(e);
  endtask

  // Monitor: after every edge compare all three DUTs against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge qzt_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          checks++;
          if ({act_v[i], act_lk[i], act_wr[i], act_o[i]} !== {e.v[i], e.lk[i], e.wr[i], e.o[i]}) begin
            errors++;
            $display("FAIL dut%0d cycle: got v=%b lk=%b wr=%b out=%h expected v=%b lk=%b wr=%b out=%h",
                     i, act_v[i], act_lk[i], act_wr[i], act_o[i], e.v[i], e.lk[i], e.wr[i], e.o[i]);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] rs;
    int wraps;
    repeat (3) @(posedge qzt_clk);
    #1;
    chk("reset_out_a", 64'(out_a), 64'd1);
    chk("reset_out_c", 64'(out_c), 64'd1);
    chk("reset_flags", {61'd0, v_a | v_b | v_c, lk_a | lk_b | lk_c, wr_a | wr_b | wr_c}, 64'd0);
    @(negedge qzt_clk);
    rst_n = 1'b1;

    repeat (10) drive(1'b0, 64'd0, 1'b0);

    drive(1'b1, 64'd1, 1'b0);
    repeat (6) drive(1'b0, 64'd0, 1'b1);
    @(posedge qzt_clk);
    #2;
    chk("seq_sixth_a", 64'(out_a), 64'h41);

    drive(1'b1, 64'd1, 1'b0);
    drive(1'b0, 64'd0, 1'b1);
    @(posedge qzt_clk);
    #2;
    chk("steps2_b", 64'(out_b), 64'd4);
    drive(1'b1, 64'h155, 1'b1);
    @(posedge qzt_clk);
    #2;
    chk("load_wins_b", 64'(out_b), 64'h155);

    // 4-bit instance: full period then a second period
    drive(1'b1, 64'd1, 1'b0);
    wraps = 0;
    repeat (30) begin
      drive(1'b0, 64'd0, 1'b1);
      @(posedge qzt_clk);
      #2;
      if (wr_c) wraps++;
    end
    chk("wrap_count_c", 64'(wraps), 64'd2);

    drive(1'b1, 64'd0, 1'b0);
    repeat (5) drive(1'b0, 64'd0, 1'b1);
    drive(1'b1, 64'd3, 1'b0);
    drive(1'b0, 64'd0, 1'b0);

    repeat (2000) begin
      if ($urandom_range(15) == 0) begin
        rs = {32'd0, $urandom} & 64'h7FFF_FFFF;
        if ($urandom_range(7) == 0) rs = 64'd0;
        drive(1'b1, rs, $urandom_range(1) == 1);
      end else begin
        drive(1'b0, 64'd0, $urandom_range(3) != 0);
      end
    end

    // Asynchronous reset between edges during an enable burst
    drive(1'b0, 64'd0, 1'b1);
    @(posedge qzt_clk);
    #3;
    rst_n = 1'b0;
    seed_load = 1'b0;
    enable    = 1'b0;
    #1;
    chk("async_out_a", 64'(out_a), 64'd1);
    chk("async_out_b", 64'(out_b), 64'd1);
    chk("async_out_c", 64'(out_c), 64'd1);
    chk("async_flags", {61'd0, v_a | v_b | v_c, lk_a | lk_b | lk_c, wr_a | wr_b | wr_c}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      st[i] = 64'd1;
      rf[i] = 64'd1;
    end
    @(posedge qzt_clk);
    @(negedge qzt_clk);
    rst_n = 1'b1;
    drive(1'b0, 64'd0, 1'b1);
    @(posedge qzt_clk);
    #2;
    chk("post_reset_a", 64'(out_a), 64'd2);
    drive(1'b0, 64'd0, 1'b0);

    repeat (3) @(negedge qzt_clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
